ram_wait: RTL and testbench
===========================

Name: ram_wait

Overview:
- Parametrised successor to the single-cycle xbus RAM.
- Adds configurable data width, non-power-of-2 depth, programmable wait-state latency with an explicit `xbus_ready` handshake, and out-of-range address error reporting.
- Adds optional hardware zero-initialisation after reset.
- Sits on the xbus as an instruction or data memory slave behind the bus decoder.

Parameters:
- DEPTH, 1024: number of words; any value ≥ 2, not necessarily a power of 2.
- DATAW, 32: word width in bits; multiple of 8; BYTEC = DATAW/8.
- LATENCY, 1: cycles from request acceptance to `xbus_ready`; legal range 1..8.
- INIT_ZERO, 1: 1 = clear every word after reset; 0 = skip clearing.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- xbus_cs  in  1  request strobe.
- xbus_we  in  1  1 = write, 0 = read.
- xbus_be  in  BYTEC  byte enables; bit i covers byte lane i.
- xbus_addr  in  `XADDRW  byte address.
- xbus_wdata  in  DATAW  write data.
- xbus_rdata  out  DATAW  read data; registered.
- xbus_ready  out  1  one-cycle completion pulse.
- xbus_err  out  1  asserted with `xbus_ready` when the address was out of range.
- init_done  out  1  high once the memory accepts requests.

Behaviour:
- Word index = `xbus_addr[$clog2(BYTEC) +: $clog2(DEPTH)]`; low $clog2(BYTEC) bits ignored.
- Out of range: full address ≥ DEPTH*BYTEC.
- Reset (`rst` high at an edge):
  - state ← INIT, or IDLE if INIT_ZERO = 0;
  - `xbus_ready` = 0, `xbus_err` = 0, `xbus_rdata` = 0;
  - `init_done` = 0, wait counter = 0, init counter = 0.
- Reset mid-operation: any in-flight request is dropped with no `xbus_ready`. A write already committed at acceptance stays committed. Reset during INIT restarts clearing from word 0.
- INIT:
  - each cycle writes 0 to word[init counter], then the counter increments;
  - after writing word DEPTH-1, go to IDLE;
  - `init_done` rises in the first IDLE cycle, i.e. DEPTH+1 cycles after reset release;
  - `xbus_cs` is ignored in INIT (no ready, no write).
- INIT_ZERO = 0: `init_done` = 1 in the first cycle after reset release; memory contents are undefined.
- IDLE:
  - `xbus_cs` = 1 at edge T accepts the request;
  - the access happens at edge T itself:
    - write: each byte lane i with `xbus_be[i]` = 1 is updated;
    - read: word loaded into an internal holding register;
  - if LATENCY = 1, set `xbus_ready` and stay in IDLE; else go to BUSY with counter = LATENCY-1.
- BUSY:
  - counter decrements each edge; at counter = 1 the next edge sets `xbus_ready` and returns to IDLE;
  - `xbus_cs` is ignored (no write, no queueing).
- Ready timing:
  - `xbus_ready` is high for exactly one cycle, the cycle T+LATENCY (T = acceptance cycle);
  - that cycle is in IDLE, so a new request may be accepted in it (back-to-back throughput one per LATENCY cycles);
  - `cs` held continuously issues a new access every LATENCY cycles.
- Read data:
  - `xbus_rdata` updates to the holding value on the same edge `xbus_ready` rises;
  - held until the next read completion;
  - writes do not change `xbus_rdata`.
- Errors:
  - out-of-range request: no memory write; `xbus_rdata` ← 0 on completion; `xbus_err` = 1 for the `xbus_ready` cycle, else 0;
  - latency is the same as a normal access.
- Read-after-write to the same word in consecutive requests returns the new data (the write commits at acceptance, before the next acceptance).
- `xbus_be` = 0 write: completes normally, memory unchanged.

Test Plan:
- Reset, DEPTH=6, INIT_ZERO=1, LATENCY=1:
  - `init_done` rises 7 cycles after reset release;
  - `cs` during INIT → no `xbus_ready`;
  - then read addr 0x14 → `xbus_rdata` = 0x00000000, ready 1 cycle after accept, `xbus_err` = 0.
- LATENCY=3:
  - write 0xDEADBEEF to 0x8, be=1111 → ready exactly 3 cycles after accept;
  - `cs` pulses during BUSY are ignored;
  - read 0x8 → 0xDEADBEEF with ready 3 cycles later.
- Byte enables:
  - write 0x11223344 to 0x4, then 0xAABBCCDD with be=0101;
  - read → 0x11BB33DD.
- Back-to-back, LATENCY=2, `cs` held high:
  - write 0x55 to word 1, then read word 1 in the ready cycle → 0x00000055;
  - ready pulses every 2 cycles.
- Out-of-range, DEPTH=6:
  - write 0xFFFFFFFF to 0x18 → `xbus_err` = 1 with ready, memory unchanged;
  - read 0x18 → `xbus_rdata` = 0, err = 1;
  - read 0x14 → err = 0.
- Reset mid-operation:
  - assert `rst` one cycle after a LATENCY=4 read is accepted → no ready pulse;
  - outputs return to 0 and INIT restarts from word 0.

Source files
------------

// File: rtl/ram_wait_if.sv
// xbus slave-side bundle for ram_wait: request strobe, byte-lane write path,
// registered read data and the ready/err completion pulse.
`ifndef XADDRW
`define XADDRW 32
`endif

interface ram_wait_if #(
  parameter int DATAW = 32
) ();
  localparam int BYTEC = DATAW / 8;

  logic               xbus_cs;
  logic               xbus_we;
  logic [BYTEC-1:0]   xbus_be;
  logic [`XADDRW-1:0] xbus_addr;
  logic [DATAW-1:0]   xbus_wdata;
  logic [DATAW-1:0]   xbus_rdata;
  logic               xbus_ready;
  logic               xbus_err;

  modport master (
    output xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata,
    input  xbus_rdata, xbus_ready, xbus_err
  );

  modport slave (
    input  xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata,
    output xbus_rdata, xbus_ready, xbus_err
  );
endinterface

// File: rtl/ram_wait.sv
// Parametrised xbus RAM slave with programmable wait states, out-of-range
// error reporting and optional zero-clearing of every word after reset.
`ifndef XADDRW
`define XADDRW 32
`endif

module ram_wait #(
  parameter int DEPTH     = 1024,
  parameter int DATAW     = 32,
  parameter int LATENCY   = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic     clk,
  input  logic     rst,
  ram_wait_if.slave xbus,
  output logic     init_done
);
  localparam int BYTEC = DATAW / 8;
  localparam int OFFB  = $clog2(BYTEC);
  localparam int IDXW  = $clog2(DEPTH);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  localparam logic [`XADDRW:0] ADDR_LIMIT = (`XADDRW + 1)'(DEPTH * BYTEC);
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(DEPTH - 1);
  localparam logic [3:0]       WAIT_LOAD  = 4'(LATENCY - 1);

  logic [DATAW-1:0] mem_r [DEPTH];

  logic [1:0]       state_r;
  logic [3:0]       wait_cnt_r;
  logic [IDXW-1:0]  init_cnt_r;
  logic             init_done_r;
  logic             ready_r;
  logic             err_r;
  logic [DATAW-1:0] rdata_r;
  logic [DATAW-1:0] hold_data_r;
  logic             hold_upd_r;
  logic             hold_err_r;

  logic             in_range_s;
  logic [IDXW-1:0]  idx_s;
  logic             accept_s;
  logic             mem_wr_s;
  logic             init_wr_s;
  logic [DATAW-1:0] acc_data_s;
  logic             acc_upd_s;

  assign in_range_s = ({1'b0, xbus.xbus_addr} < ADDR_LIMIT);
  assign idx_s      = IDXW'(xbus.xbus_addr >> OFFB);
  // Requests are only taken once init_done is visible to the master.
  assign accept_s   = (state_r == ST_IDLE) && init_done_r && xbus.xbus_cs;
  assign mem_wr_s   = !rst && accept_s && xbus.xbus_we && in_range_s;
  assign init_wr_s  = !rst && (state_r == ST_INIT);
  assign acc_data_s = in_range_s ? mem_r[idx_s] : {DATAW{1'b0}};
  // Reads and any out-of-range access refresh rdata; good writes leave it alone.
  assign acc_upd_s  = !xbus.xbus_we || !in_range_s;

  assign xbus.xbus_rdata = rdata_r;
  assign xbus.xbus_ready = ready_r;
  assign xbus.xbus_err   = err_r;
  assign init_done       = init_done_r;

  // Storage: zero-clear sweep during INIT, byte-lane writes at acceptance.
  always_ff @(posedge clk) begin
    if (init_wr_s) begin
      mem_r[init_cnt_r] <= {DATAW{1'b0}};
    end else if (mem_wr_s) begin
      for (int i = 0; i < BYTEC; i++) begin
        if (xbus.xbus_be[i]) begin
          mem_r[idx_s][8*i +: 8] <= xbus.xbus_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM, wait-state counter and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
      wait_cnt_r  <= 4'd0;
      init_cnt_r  <= {IDXW{1'b0}};
      init_done_r <= 1'b0;
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
      rdata_r     <= {DATAW{1'b0}};
      hold_data_r <= {DATAW{1'b0}};
      hold_upd_r  <= 1'b0;
      hold_err_r  <= 1'b0;
    end else begin
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
      init_done_r <= (state_r != ST_INIT);
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + {{(IDXW-1){1'b0}}, 1'b1};
          if (init_cnt_r == LAST_IDX) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            if (LATENCY == 1) begin
              ready_r <= 1'b1;
              err_r   <= !in_range_s;
              if (acc_upd_s) begin
                rdata_r <= acc_data_s;
              end
            end else begin
              state_r     <= ST_BUSY;
              wait_cnt_r  <= WAIT_LOAD;
              hold_data_r <= acc_data_s;
              hold_upd_r  <= acc_upd_s;
              hold_err_r  <= !in_range_s;
            end
          end
        end
        ST_BUSY: begin
          wait_cnt_r <= wait_cnt_r - 4'd1;
          if (wait_cnt_r == 4'd1) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            err_r   <= hold_err_r;
            if (hold_upd_r) begin
              rdata_r <= hold_data_r;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_wait.sv
// Directed bench for ram_wait: five DEPTH=6 instances covering LATENCY 1/3/2/4
// and an INIT_ZERO=0 variant, sharing clk/rst and the request data lines.
module tb_ram_wait;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_v    [5];
  logic        ready_v [5];
  logic        err_v   [5];
  logic        done_v  [5];
  logic [31:0] rdata_a [5];
  logic        we_s;
  logic [3:0]  be_s;
  logic [31:0] addr_s;
  logic [31:0] wd_s;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Instance 0: L=1, 1: L=3, 2: L=2, 3: L=4, 4: L=1 without clearing.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : (g == 2) ? 2 : (g == 3) ? 4 : 1;
    localparam int INZ = (g == 4) ? 0 : 1;
    ram_wait_if #(.DATAW(32)) bus ();
    assign bus.xbus_cs    = cs_v[g];
    assign bus.xbus_we    = we_s;
    assign bus.xbus_be    = be_s;
    assign bus.xbus_addr  = addr_s;
    assign bus.xbus_wdata = wd_s;
    assign ready_v[g]     = bus.xbus_ready;
    assign err_v[g]       = bus.xbus_err;
    assign rdata_a[g]     = bus.xbus_rdata;
    ram_wait #(.DEPTH(6), .DATAW(32), .LATENCY(LAT), .INIT_ZERO(INZ)) dut (
      .clk(clk), .rst(rst), .xbus(bus), .init_done(done_v[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on instance k; returns edges from acceptance (inclusive) to ready.
  task automatic xfer(input int k, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd, output int lat);
    we_s = we; be_s = be; addr_s = addr; wd_s = wd; cs_v[k] = 1'b1;
    tick();
    cs_v[k] = 1'b0;
    lat = 1;
    while (ready_v[k] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int n;
    int lat;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) cs_v[k] = 1'b0;
    we_s = 1'b0; be_s = 4'h0; addr_s = 32'h0; wd_s = 32'h0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ready_v[k] !== 1'b0 || err_v[k] !== 1'b0 || done_v[k] !== 1'b0 || rdata_a[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: ready=%b err=%b done=%b rdata=%h, expected all zero",
                 k, ready_v[k], err_v[k], done_v[k], rdata_a[k]);
      end
    end
    we_s = 1'b1; be_s = 4'hF; addr_s = 32'h14; wd_s = 32'hFFFF_FFFF; cs_v[0] = 1'b1;
    rst = 1'b0;
    n = 0;
    while (done_v[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (done_v[4] !== 1'b1) begin
          failures++;
          $display("FAIL noinit_done: init_done=%b one cycle after release, expected 1", done_v[4]);
        end
      end
      if (n <= 5) begin
        checks++;
        if (ready_v[0] !== 1'b0) begin
          failures++;
          $display("FAIL init_ignores_cs: ready=%b at cycle %0d, expected 0", ready_v[0], n);
        end
        if (n == 5) cs_v[0] = 1'b0;
      end
    end
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL init_done_delay: rose after %0d cycles, expected 7", n);
    end
    xfer(0, 1'b0, 4'hF, 32'h14, 32'h0, lat);
    checks++;
    if (lat !== 1 || rdata_a[0] !== 32'h0 || err_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL init_read: lat=%0d rdata=%h err=%b, expected lat=1 rdata=00000000 err=0",
               lat, rdata_a[0], err_v[0]);
    end
  endtask

  task automatic test_latency();
    int lat;
    we_s = 1'b1; be_s = 4'hF; addr_s = 32'h8; wd_s = 32'hDEAD_BEEF; cs_v[1] = 1'b1;
    tick();
    cs_v[1] = 1'b0;
    checks++;
    if (ready_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL lat3_gap1: ready=%b, expected 0", ready_v[1]);
    end
    wd_s = 32'h1234_5678; cs_v[1] = 1'b1;
    tick();
    cs_v[1] = 1'b0;
    checks++;
    if (ready_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL lat3_gap2: ready=%b, expected 0", ready_v[1]);
    end
    tick();
    checks++;
    if (ready_v[1] !== 1'b1 || err_v[1] !== 1'b0 || rdata_a[1] !== 32'h0) begin
      failures++;
      $display("FAIL lat3_write_done: ready=%b err=%b rdata=%h, expected ready=1 err=0 rdata=00000000",
               ready_v[1], err_v[1], rdata_a[1]);
    end
    tick();
    checks++;
    if (ready_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL lat3_pulse_width: ready=%b, expected 0", ready_v[1]);
    end
    xfer(1, 1'b0, 4'hF, 32'h8, 32'h0, lat);
    checks++;
    if (lat !== 3 || rdata_a[1] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lat3_read: lat=%0d rdata=%h, expected lat=3 rdata=deadbeef", lat, rdata_a[1]);
    end
  endtask

  task automatic test_byte_enable();
    int lat;
    xfer(1, 1'b1, 4'hF, 32'h4, 32'h1122_3344, lat);
    xfer(1, 1'b1, 4'h5, 32'h4, 32'hAABB_CCDD, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL be_write_lat: lat=%0d, expected 3", lat);
    end
    xfer(1, 1'b0, 4'hF, 32'h4, 32'h0, lat);
    checks++;
    if (rdata_a[1] !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL be_merge: rdata=%h, expected 11bb33dd", rdata_a[1]);
    end
    xfer(1, 1'b1, 4'h0, 32'h4, 32'h0, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL be_zero_lat: lat=%0d, expected 3", lat);
    end
    xfer(1, 1'b0, 4'hF, 32'h4, 32'h0, lat);
    checks++;
    if (rdata_a[1] !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL be_zero_nochange: rdata=%h, expected 11bb33dd", rdata_a[1]);
    end
  endtask

  task automatic test_back_to_back();
    we_s = 1'b1; be_s = 4'hF; addr_s = 32'h4; wd_s = 32'h55; cs_v[2] = 1'b1;
    tick();
    checks++;
    if (ready_v[2] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap0: ready=%b, expected 0", ready_v[2]);
    end
    tick();
    checks++;
    if (ready_v[2] !== 1'b1 || rdata_a[2] !== 32'h0) begin
      failures++;
      $display("FAIL b2b_write_done: ready=%b rdata=%h, expected ready=1 rdata=00000000",
               ready_v[2], rdata_a[2]);
    end
    we_s = 1'b0; wd_s = 32'h0;
    tick();
    checks++;
    if (ready_v[2] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap1: ready=%b, expected 0", ready_v[2]);
    end
    tick();
    cs_v[2] = 1'b0;
    checks++;
    if (ready_v[2] !== 1'b1 || rdata_a[2] !== 32'h0000_0055) begin
      failures++;
      $display("FAIL b2b_read: ready=%b rdata=%h, expected ready=1 rdata=00000055",
               ready_v[2], rdata_a[2]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    int lat;
    xfer(0, 1'b1, 4'hF, 32'h14, 32'hCAFE_F00D, lat);
    xfer(0, 1'b0, 4'hF, 32'h14, 32'h0, lat);
    checks++;
    if (rdata_a[0] !== 32'hCAFE_F00D || err_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL oor_setup: rdata=%h err=%b, expected cafef00d err=0", rdata_a[0], err_v[0]);
    end
    xfer(0, 1'b1, 4'hF, 32'h18, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat !== 1 || err_v[0] !== 1'b1 || rdata_a[0] !== 32'h0) begin
      failures++;
      $display("FAIL oor_write: lat=%0d err=%b rdata=%h, expected lat=1 err=1 rdata=00000000",
               lat, err_v[0], rdata_a[0]);
    end
    tick();
    checks++;
    if (err_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL oor_err_width: err=%b, expected 0", err_v[0]);
    end
    xfer(0, 1'b0, 4'hF, 32'h18, 32'h0, lat);
    checks++;
    if (lat !== 1 || err_v[0] !== 1'b1 || rdata_a[0] !== 32'h0) begin
      failures++;
      $display("FAIL oor_read: lat=%0d err=%b rdata=%h, expected lat=1 err=1 rdata=00000000",
               lat, err_v[0], rdata_a[0]);
    end
    xfer(0, 1'b0, 4'hF, 32'h17, 32'h0, lat);
    checks++;
    if (err_v[0] !== 1'b0 || rdata_a[0] !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL oor_last_word: err=%b rdata=%h, expected err=0 rdata=cafef00d", err_v[0], rdata_a[0]);
    end
    xfer(0, 1'b0, 4'hF, 32'h0, 32'h0, lat);
    checks++;
    if (err_v[0] !== 1'b0 || rdata_a[0] !== 32'h0) begin
      failures++;
      $display("FAIL oor_word0_intact: err=%b rdata=%h, expected err=0 rdata=00000000", err_v[0], rdata_a[0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    bit seen;
    xfer(3, 1'b1, 4'hF, 32'h0, 32'h77, lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL lat4_write: lat=%0d, expected 4", lat);
    end
    xfer(3, 1'b0, 4'hF, 32'h0, 32'h0, lat);
    checks++;
    if (rdata_a[3] !== 32'h77) begin
      failures++;
      $display("FAIL lat4_read: rdata=%h, expected 00000077", rdata_a[3]);
    end
    we_s = 1'b0; addr_s = 32'h0; cs_v[3] = 1'b1;
    tick();
    cs_v[3] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready_v[3] !== 1'b0 || err_v[3] !== 1'b0 || rdata_a[3] !== 32'h0 || done_v[3] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: ready=%b err=%b rdata=%h done=%b, expected all zero",
               ready_v[3], err_v[3], rdata_a[3], done_v[3]);
    end
    n = 0;
    seen = 1'b0;
    while (done_v[3] !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (ready_v[3] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_ready: ready seen=%b, expected 0", seen);
    end
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL mid_reset_reinit: init_done after %0d cycles, expected 7", n);
    end
    xfer(3, 1'b0, 4'hF, 32'h0, 32'h0, lat);
    checks++;
    if (lat !== 4 || rdata_a[3] !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_cleared: lat=%0d rdata=%h, expected lat=4 rdata=00000000", lat, rdata_a[3]);
    end
  endtask

  initial begin
    for (int k = 0; k < 5; k++) cs_v[k] = 1'b0;
    test_reset();
    test_latency();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
